ttl_modulo_loader: RTL

Synchronous control stage that sits directly upstream of a 4-bit (WIDTH-bit) synchronous binary counter with parallel load and RCO. It drives the counter's Load_bar, ENT, ENP and D, and watches its RCO to build a programmable modulo-N period generator. It supports start, pause/resume, abort and one-shot modes. It emits one Tick pulse per completed period and keeps a count of periods.

---
 rtl/ttl_modulo_loader_pkg.sv | 14 +
 rtl/ttl_modulo_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/ttl_modulo_loader_pkg.sv
// Shared types for the modulo-N loader that drives a synchronous binary counter.
package ttl_modulo_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PRESET = 2'b01,
        RUN    = 2'b10,
        HOLD   = 2'b11
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/ttl_modulo_loader.sv
// Programmable modulo-N period generator controlling a loadable counter through Load_bar/ENT/ENP/D.
// Optional period counter enabled by defining TTL_MODULO_LOADER_PERIODS_EN.
module ttl_modulo_loader
    import ttl_modulo_loader_pkg::*;
#(
    parameter int WIDTH      = 4,
    // Delays belong to the timing model only; the synthesized logic is zero-delay.
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Modulus,
    input  logic             RCO_in,
    output logic             Load_bar,
    output logic             ENT,
    output logic             ENP,
    output logic [WIDTH-1:0] D,
    output logic             Busy,
    output logic             Tick,
    output logic [7:0]       Periods
);

    state_t           state_p0;
    logic [WIDTH-1:0] n_latched_p0;
    logic             mode_p0;
    logic             tick_p0;

    // Counter must reach all-ones after N counts, so preset is -N; N=0 yields 0 and a 2^WIDTH period.
    function automatic logic [WIDTH-1:0] preset_of(input logic [WIDTH-1:0] n);
        return '0 - n;
    endfunction

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_p0     <= IDLE;
            n_latched_p0 <= '0;
            mode_p0      <= MODE_PERIODIC;
            tick_p0      <= 1'b0;
        end else begin
            tick_p0 <= 1'b0;
            case (state_p0)
                IDLE: begin
                    if (Start && !Stop) begin
                        state_p0     <= PRESET;
                        n_latched_p0 <= Modulus;
                        mode_p0      <= Mode;
                    end
                end
                PRESET: state_p0 <= Stop ? IDLE : RUN;
                RUN: begin
                    // A terminal always completes, even when Stop arrives on the same edge.
                    if (RCO_in) begin
                        tick_p0 <= 1'b1;
                        if (mode_p0 == MODE_ONESHOT) state_p0 <= IDLE;
                        else if (Stop)               state_p0 <= HOLD;
                    end else if (Stop) begin
                        state_p0 <= HOLD;
                    end
                end
                HOLD: begin
                    if (Stop)       state_p0 <= IDLE;
                    else if (Start) state_p0 <= RUN;
                end
                default: state_p0 <= IDLE;
            endcase
        end
    end

`ifdef TTL_MODULO_LOADER_PERIODS_EN
    logic [7:0] periods_p0;

    always_ff @(posedge Clk) begin
        if (Clear) begin
            periods_p0 <= 8'd0;
        end else if (state_p0 == IDLE && Start && !Stop) begin
            periods_p0 <= 8'd0;
        end else if (state_p0 == RUN && RCO_in) begin
            periods_p0 <= periods_p0 + 8'd1;
        end
    end

    assign Periods = periods_p0;
`else
    assign Periods = 8'd0;
`endif

    // Load_bar is the only output with a combinational path from an input (RCO reload in RUN).
    always_comb begin
        Load_bar = 1'b1;
        ENT      = 1'b0;
        case (state_p0)
            PRESET:  Load_bar = 1'b0;
            RUN: begin
                Load_bar = !RCO_in;
                ENT      = 1'b1;
            end
            default: begin
                Load_bar = 1'b1;
                ENT      = 1'b0;
            end
        endcase
    end

    assign ENP  = ENT;
    assign D    = preset_of(n_latched_p0);
    assign Busy = (state_p0 != IDLE);
    assign Tick = tick_p0;

endmodule
